// File: rtl/sdiv_32_32.sv
// Iterative radix-2 restoring divider for DIV/DIVU/REM/REMU on 33-bit sign/zero-extended operands.
// Trivial cases (divide by zero, |a|<|b|) skip the iteration and finish in one cycle.
module sdiv_32_32 #(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [XLEN:0]   ai,
    input  logic [XLEN:0]   bi,
    input  logic            req,
    output logic [XLEN-1:0] quot,
    output logic [XLEN-1:0] rem,
    output logic            rdy,
    output logic            busy
);

    localparam int unsigned CW = $clog2(XLEN);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_FIX  = 2'd2;

    logic [1:0]      r_state;
    logic [CW-1:0]   r_cnt;
    logic            r_sign_a;
    logic            r_sign_b;
    logic            r_dz;
    logic [XLEN-1:0] r_b;
    logic [XLEN-1:0] r_p;
    logic [XLEN-1:0] r_q;
    logic [XLEN-1:0] r_quot;
    logic [XLEN-1:0] r_rem;
    logic            r_rdy;

    logic            w_accept;
    logic            w_short;
    logic [XLEN-1:0] w_mag_a;
    logic [XLEN-1:0] w_mag_b;
    logic [XLEN:0]   w_p_sh;
    logic            w_ge;
    logic [XLEN-1:0] w_p_diff;
    logic [XLEN-1:0] w_quot;
    logic [XLEN-1:0] w_rem;

    // A held req is ignored while rdy is up, so one request yields one result.
    assign w_accept = (r_state == S_IDLE) && req && !r_rdy;

    assign w_mag_a  = ai[XLEN] ? ('0 - ai[XLEN-1:0]) : ai[XLEN-1:0];
    assign w_mag_b  = bi[XLEN] ? ('0 - bi[XLEN-1:0]) : bi[XLEN-1:0];
    assign w_short  = (w_mag_b == '0) || (w_mag_a < w_mag_b);

    // Shifted partial remainder needs one extra bit: |b| can be up to 2^XLEN-1.
    assign w_p_sh   = {r_p, r_q[XLEN-1]};
    assign w_ge     = w_p_sh >= {1'b0, r_b};
    assign w_p_diff = w_p_sh[XLEN-1:0] - r_b;

    // Short path leaves P=|a|, Q=0, so the normal sign fix-up restores rem = a.
    assign w_quot   = r_dz ? '1 : ((r_sign_a ^ r_sign_b) ? ('0 - r_q) : r_q);
    assign w_rem    = r_sign_a ? ('0 - r_p) : r_p;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_sign_a <= 1'b0;
            r_sign_b <= 1'b0;
            r_dz     <= 1'b0;
            r_b      <= '0;
            r_p      <= '0;
            r_q      <= '0;
            r_quot   <= '0;
            r_rem    <= '0;
            r_rdy    <= 1'b0;
        end else begin
            r_rdy <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_sign_a <= ai[XLEN];
                        r_sign_b <= bi[XLEN];
                        r_b      <= w_mag_b;
                        r_dz     <= (w_mag_b == '0);
                        r_cnt    <= '0;
                        if (w_short) begin
                            r_p     <= w_mag_a;
                            r_q     <= '0;
                            r_state <= S_FIX;
                        end else begin
                            r_p     <= '0;
                            r_q     <= w_mag_a;
                            r_state <= S_CALC;
                        end
                    end
                end
                S_CALC: begin
                    r_p   <= w_ge ? w_p_diff : w_p_sh[XLEN-1:0];
                    r_q   <= {r_q[XLEN-2:0], w_ge};
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == CW'(XLEN - 1)) begin
                        r_state <= S_FIX;
                    end
                end
                S_FIX: begin
                    r_quot  <= w_quot;
                    r_rem   <= w_rem;
                    r_rdy   <= 1'b1;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign quot = r_quot;
    assign rem  = r_rem;
    assign rdy  = r_rdy;
    assign busy = (r_state != S_IDLE);

endmodule

// File: tb/tb_sdiv_32_32.sv
// Directed-vector bench for sdiv_32_32: results, latency, held-req handling and mid-op reset.
module tb_sdiv_32_32;

    logic        clk;
    logic        rst_n;
    logic [32:0] ai;
    logic [32:0] bi;
    logic        req;
    logic [31:0] quot;
    logic [31:0] rem;
    logic        rdy;
    logic        busy;

    int n_checks;
    int n_errors;

    sdiv_32_32 #(.XLEN(32)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .ai    (ai),
        .bi    (bi),
        .req   (req),
        .quot  (quot),
        .rem   (rem),
        .rdy   (rdy),
        .busy  (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Issues one division with req held through the rdy cycle, then checks result and latency.
    task automatic do_div(input string name, input logic [32:0] a, input logic [32:0] b,
                          input logic [31:0] exp_q, input logic [31:0] exp_r, input int exp_lat);
        int n;
        @(negedge clk);
        ai  = a;
        bi  = b;
        req = 1'b1;
        @(posedge clk);
        n = 0;
        while (n < 100) begin
            @(posedge clk);
            #1;
            n++;
            if (n == 1) check({name, " busy1"}, {31'd0, busy}, {31'd0, exp_lat > 1});
            if (rdy) break;
        end
        check({name, " lat"}, n, exp_lat);
        check({name, " quot"}, quot, exp_q);
        check({name, " rem"}, rem, exp_r);
        @(posedge clk);
        #1;
        check({name, " rdy_pulse"}, {31'd0, rdy}, 32'd0);
        check({name, " no_reissue"}, {31'd0, busy}, 32'd0);
        req = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst_n    = 1'b0;
        req      = 1'b0;
        ai       = '0;
        bi       = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst quot", quot, 32'd0);
        check("rst rem", rem, 32'd0);
        check("rst rdy", {31'd0, rdy}, 32'd0);
        check("rst busy", {31'd0, busy}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        do_div("100/7",   33'h0_00000064, 33'h0_00000007, 32'h0000000E, 32'h00000002, 33);
        do_div("-100/7",  33'h1_FFFFFF9C, 33'h0_00000007, 32'hFFFFFFF2, 32'hFFFFFFFE, 33);
        do_div("div0",    33'h0_12345678, 33'h0_00000000, 32'hFFFFFFFF, 32'h12345678, 1);
        do_div("ovf",     33'h1_80000000, 33'h1_FFFFFFFF, 32'h80000000, 32'h00000000, 33);
        do_div("umax/2",  33'h0_FFFFFFFF, 33'h0_00000002, 32'h7FFFFFFF, 32'h00000001, 33);
        do_div("3/5",     33'h0_00000003, 33'h0_00000005, 32'h00000000, 32'h00000003, 1);
        do_div("-7/-2",   33'h1_FFFFFFF9, 33'h1_FFFFFFFE, 32'h00000003, 32'hFFFFFFFF, 33);
        do_div("-3/5",    33'h1_FFFFFFFD, 33'h0_00000005, 32'h00000000, 32'hFFFFFFFD, 1);
        do_div("5/5",     33'h0_00000005, 33'h0_00000005, 32'h00000001, 32'h00000000, 33);

        // Abort a full division after 10 cycles with an asynchronous reset.
        @(negedge clk);
        ai  = 33'h0_00000064;
        bi  = 33'h0_00000007;
        req = 1'b1;
        @(posedge clk);
        repeat (10) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("abort rdy", {31'd0, rdy}, 32'd0);
        check("abort busy", {31'd0, busy}, 32'd0);
        check("abort quot", quot, 32'd0);
        check("abort rem", rem, 32'd0);
        req = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        do_div("100/7 again", 33'h0_00000064, 33'h0_00000007, 32'h0000000E, 32'h00000002, 33);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
